// File: rtl/ysyx_24100006_mem_access_if.sv
// ysyx_24100006_mem_access_if: EXE_MEM input, data bus and MEM_WB output bundle of the memory-access stage
interface ysyx_24100006_mem_access_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       alu_result_i;
  logic [DATA_W-1:0] wdata_gpr_i;
  logic [DATA_W-1:0] store_data_i;
  logic [1:0]        sram_read_write_i;
  logic [2:0]        Mem_Mask_i;
  logic [3:0]        Gpr_Write_Addr_i;
  logic              Gpr_Write_i;
  logic              flush_i;
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic              mem_req_we;
  logic [ADDR_W-1:0] mem_req_addr;
  logic [DATA_W-1:0] mem_req_wdata;
  logic [3:0]        mem_req_wstrb;
  logic              mem_resp_valid;
  logic [DATA_W-1:0] mem_resp_rdata;
  logic              mem_resp_err;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] wb_data_o;
  logic [3:0]        Gpr_Write_Addr_o;
  logic              Gpr_Write_o;
  logic              misalign_o;
  logic              access_fault_o;
  modport master (
    input  in_valid, alu_result_i, wdata_gpr_i, store_data_i, sram_read_write_i, Mem_Mask_i,
           Gpr_Write_Addr_i, Gpr_Write_i, flush_i, mem_req_ready, mem_resp_valid, mem_resp_rdata,
           mem_resp_err, out_ready,
    output in_ready, mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_wstrb,
           out_valid, wb_data_o, Gpr_Write_Addr_o, Gpr_Write_o, misalign_o, access_fault_o
  );
  modport slave (
    output in_valid, alu_result_i, wdata_gpr_i, store_data_i, sram_read_write_i, Mem_Mask_i,
           Gpr_Write_Addr_i, Gpr_Write_i, flush_i, mem_req_ready, mem_resp_valid, mem_resp_rdata,
           mem_resp_err, out_ready,
    input  in_ready, mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_wstrb,
           out_valid, wb_data_o, Gpr_Write_Addr_o, Gpr_Write_o, misalign_o, access_fault_o
  );
endinterface

// File: rtl/ysyx_24100006_mem_access.sv
// ysyx_24100006_mem_access: MEM stage turning each EXE_MEM entry into at most one data-bus transaction
module ysyx_24100006_mem_access #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input logic clk,
  input logic reset,
  ysyx_24100006_mem_access_if.master bus
);
  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] sdata_q, wb_q, sh, ext;
  logic [2:0] mask_q;
  logic [3:0] waddr_q, waddr_o_q;
  logic [1:0] a;
  logic we_q, gw_q, drop_q, out_valid_q, gw_o_q, mis_q, fault_q;
  logic accept, mem_op, mis, direct, done, load_new;
  assign mem_op = ^bus.sram_read_write_i;
  assign mis = bus.Mem_Mask_i[1] ? |bus.alu_result_i[1:0] : bus.Mem_Mask_i[0] & bus.alu_result_i[0];
  assign bus.in_ready = state_q == IDLE && !bus.flush_i && (!out_valid_q || bus.out_ready);
  assign accept = bus.in_valid && bus.in_ready;
  assign direct = accept && (!mem_op || mis);
  assign done = state_q == RESP && bus.mem_resp_valid;
  // a transaction flushed while in flight still completes, but its result is dropped
  assign load_new = direct || (done && !drop_q && !bus.flush_i);
  assign a = addr_q[1:0];
  assign sh = bus.mem_resp_rdata >> {a, 3'b000};
  assign ext = mask_q[1] ? sh :
               mask_q[0] ? {{16{sh[15] & ~mask_q[2]}}, sh[15:0]} :
                           {{24{sh[7] & ~mask_q[2]}}, sh[7:0]};
  assign bus.mem_req_valid = state_q == REQ;
  assign bus.mem_req_we = we_q;
  assign bus.mem_req_addr = addr_q;
  assign bus.mem_req_wdata = mask_q[1] ? sdata_q : mask_q[0] ? {2{sdata_q[15:0]}} : {4{sdata_q[7:0]}};
  assign bus.mem_req_wstrb = !we_q ? 4'b0000 : mask_q[1] ? 4'b1111 : mask_q[0] ? 4'b0011 << a : 4'b0001 << a;
  assign bus.out_valid = out_valid_q;
  assign bus.wb_data_o = wb_q;
  assign bus.Gpr_Write_Addr_o = waddr_o_q;
  assign bus.Gpr_Write_o = gw_o_q;
  assign bus.misalign_o = mis_q;
  assign bus.access_fault_o = fault_q;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept && mem_op && !mis) state_d = REQ;
      REQ: if (bus.mem_req_ready) state_d = RESP;
      RESP: if (bus.mem_resp_valid) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q <= '0;
      sdata_q <= '0;
      mask_q <= '0;
      waddr_q <= '0;
      we_q <= 1'b0;
      gw_q <= 1'b0;
      drop_q <= 1'b0;
      out_valid_q <= 1'b0;
      wb_q <= '0;
      waddr_o_q <= '0;
      gw_o_q <= 1'b0;
      mis_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      drop_q <= state_q == IDLE ? 1'b0 : drop_q | bus.flush_i;
      if (accept) begin
        addr_q <= bus.alu_result_i[ADDR_W-1:0];
        sdata_q <= bus.store_data_i;
        mask_q <= bus.Mem_Mask_i;
        waddr_q <= bus.Gpr_Write_Addr_i;
        we_q <= bus.sram_read_write_i == 2'b10;
        gw_q <= bus.Gpr_Write_i;
      end
      if (load_new) begin
        out_valid_q <= 1'b1;
        wb_q <= direct ? (mem_op ? '0 : bus.wdata_gpr_i) : ext;
        waddr_o_q <= direct ? bus.Gpr_Write_Addr_i : waddr_q;
        gw_o_q <= direct ? bus.Gpr_Write_i & !mem_op : gw_q & !bus.mem_resp_err;
        mis_q <= direct & mem_op;
        fault_q <= !direct & bus.mem_resp_err;
      end else if (bus.flush_i || bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_ysyx_24100006_mem_access.sv
// tb_ysyx_24100006_mem_access: directed stimulus with request/result scoreboards and a bus slave model
module tb_ysyx_24100006_mem_access;
  logic clk = 1'b0;
  logic reset;
  int n_chk = 0;
  int n_fail = 0;
  int slv_delay = 0;
  int slv_rdelay = 0;
  logic [31:0] slv_rdata = '0;
  logic slv_err = 1'b0;
  typedef struct {logic [31:0] wb; logic wb_x; logic [3:0] wa; logic gw, mis, flt;} out_t;
  typedef struct {logic [31:0] addr, wdata; logic we; logic [3:0] wstrb;} req_t;
  out_t oq[$];
  req_t rq[$];
  ysyx_24100006_mem_access_if bus ();
  ysyx_24100006_mem_access dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic exp_out(input logic [31:0] wb, input logic wb_x, input logic [3:0] wa, input logic gw, mis, flt);
    out_t e;
    e.wb = wb; e.wb_x = wb_x; e.wa = wa; e.gw = gw; e.mis = mis; e.flt = flt;
    oq.push_back(e);
  endtask
  task automatic exp_req(input logic [31:0] addr, input logic we, input logic [31:0] wdata, input logic [3:0] wstrb);
    req_t r;
    r.addr = addr; r.we = we; r.wdata = wdata; r.wstrb = wstrb;
    rq.push_back(r);
  endtask
  always @(negedge clk) begin
    if (!reset && bus.out_valid && bus.out_ready) begin
      if (oq.size() == 0) chk("unexpected_result", 32'd1, 32'd0);
      else begin
        out_t e;
        e = oq.pop_front();
        if (!e.wb_x) chk("wb_data", bus.wb_data_o, e.wb);
        chk("wb_addr", {28'd0, bus.Gpr_Write_Addr_o}, {28'd0, e.wa});
        chk("gpr_write", {31'd0, bus.Gpr_Write_o}, {31'd0, e.gw});
        chk("misalign", {31'd0, bus.misalign_o}, {31'd0, e.mis});
        chk("access_fault", {31'd0, bus.access_fault_o}, {31'd0, e.flt});
      end
    end
  end
  always @(negedge clk) begin
    if (!reset && bus.mem_req_valid) begin
      if (rq.size() == 0) chk("unexpected_request", 32'd1, 32'd0);
      else begin
        chk("req_addr", bus.mem_req_addr, rq[0].addr);
        chk("req_we", {31'd0, bus.mem_req_we}, {31'd0, rq[0].we});
        chk("req_wstrb", {28'd0, bus.mem_req_wstrb}, {28'd0, rq[0].wstrb});
        if (rq[0].we) chk("req_wdata", bus.mem_req_wdata, rq[0].wdata);
        if (bus.mem_req_ready) void'(rq.pop_front());
      end
    end
  end
  initial begin
    int ph = 0;
    int cnt = 0;
    bus.mem_req_ready = 1'b0;
    bus.mem_resp_valid = 1'b0;
    bus.mem_resp_rdata = '0;
    bus.mem_resp_err = 1'b0;
    forever begin
      @(posedge clk); #1;
      bus.mem_resp_valid = 1'b0;
      if (ph == 0) begin
        if (bus.mem_req_ready) begin
          bus.mem_req_ready = 1'b0; ph = 1; cnt = 0;
        end else if (bus.mem_req_valid) begin
          if (cnt >= slv_delay) bus.mem_req_ready = 1'b1;
          else cnt++;
        end else cnt = 0;
      end
      if (ph == 1) begin
        if (cnt >= slv_rdelay) begin
          bus.mem_resp_valid = 1'b1; bus.mem_resp_rdata = slv_rdata; bus.mem_resp_err = slv_err;
          ph = 0; cnt = 0;
        end else cnt++;
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
  task automatic send(input logic [31:0] alu, wd, sd, input logic [1:0] rw, input logic [2:0] mk,
                      input logic [3:0] wa, input logic gw);
    int n = 0;
    bus.alu_result_i = alu; bus.wdata_gpr_i = wd; bus.store_data_i = sd;
    bus.sram_read_write_i = rw; bus.Mem_Mask_i = mk; bus.Gpr_Write_Addr_i = wa; bus.Gpr_Write_i = gw;
    bus.in_valid = 1'b1;
    @(negedge clk);
    while (!bus.in_ready && n < 50) begin @(negedge clk); n++; end
    if (!bus.in_ready) chk("accept_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask
  task automatic drain();
    int n = 0;
    @(negedge clk);
    while ((oq.size() != 0 || !bus.in_ready) && n < 100) begin @(negedge clk); n++; end
    if (oq.size() != 0 || !bus.in_ready) chk("drain_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
  endtask
  initial begin
    int n;
    reset = 1'b1;
    bus.in_valid = 1'b0; bus.flush_i = 1'b0; bus.out_ready = 1'b1;
    bus.alu_result_i = '0; bus.wdata_gpr_i = '0; bus.store_data_i = '0;
    bus.sram_read_write_i = '0; bus.Mem_Mask_i = '0; bus.Gpr_Write_Addr_i = '0; bus.Gpr_Write_i = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_req_valid", {31'd0, bus.mem_req_valid}, 32'd0);
    chk("rst_wb_data", bus.wb_data_o, 32'd0);
    chk("rst_wb_addr", {28'd0, bus.Gpr_Write_Addr_o}, 32'd0);
    chk("rst_flags", {29'd0, bus.Gpr_Write_o, bus.misalign_o, bus.access_fault_o}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    @(posedge clk); #1;
    exp_out(32'h1234, 1'b0, 4'd5, 1'b1, 1'b0, 1'b0);
    send(32'h1234, 32'h1234, 32'h0, 2'b00, 3'b010, 4'd5, 1'b1);
    chk("nonmem_latency", {31'd0, bus.out_valid}, 32'd1);
    chk("nonmem_no_req", {31'd0, bus.mem_req_valid}, 32'd0);
    drain();
    slv_rdata = 32'h80FF_0000;
    exp_req(32'h8000_0003, 1'b0, 32'h0, 4'b0000);
    exp_out(32'hFFFF_FF80, 1'b0, 4'd7, 1'b1, 1'b0, 1'b0);
    send(32'h8000_0003, 32'h0, 32'h0, 2'b01, 3'b000, 4'd7, 1'b1);
    drain();
    exp_req(32'h8000_0003, 1'b0, 32'h0, 4'b0000);
    exp_out(32'h0000_0080, 1'b0, 4'd7, 1'b1, 1'b0, 1'b0);
    send(32'h8000_0003, 32'h0, 32'h0, 2'b01, 3'b100, 4'd7, 1'b1);
    drain();
    slv_rdata = 32'h8001_1234;
    exp_req(32'h8000_0002, 1'b0, 32'h0, 4'b0000);
    exp_out(32'hFFFF_8001, 1'b0, 4'd3, 1'b1, 1'b0, 1'b0);
    send(32'h8000_0002, 32'h0, 32'h0, 2'b01, 3'b001, 4'd3, 1'b1);
    drain();
    exp_req(32'h8000_0002, 1'b0, 32'h0, 4'b0000);
    exp_out(32'h0000_8001, 1'b0, 4'd3, 1'b1, 1'b0, 1'b0);
    send(32'h8000_0002, 32'h0, 32'h0, 2'b01, 3'b101, 4'd3, 1'b1);
    drain();
    exp_req(32'h8000_0000, 1'b0, 32'h0, 4'b0000);
    exp_out(32'h8001_1234, 1'b0, 4'd9, 1'b1, 1'b0, 1'b0);
    send(32'h8000_0000, 32'h0, 32'h0, 2'b01, 3'b010, 4'd9, 1'b1);
    drain();
    slv_delay = 3;
    exp_req(32'h8000_0002, 1'b1, 32'hBEEF_BEEF, 4'b1100);
    exp_out(32'h0, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0);
    send(32'h8000_0002, 32'h0, 32'hAAAA_BEEF, 2'b10, 3'b001, 4'd0, 1'b0);
    drain();
    slv_delay = 0;
    exp_req(32'h8000_0001, 1'b1, 32'h7878_7878, 4'b0010);
    exp_out(32'h0, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0);
    send(32'h8000_0001, 32'h0, 32'h1234_5678, 2'b10, 3'b000, 4'd0, 1'b0);
    drain();
    exp_out(32'h0, 1'b1, 4'd6, 1'b0, 1'b1, 1'b0);
    send(32'h8000_0001, 32'h0, 32'h0, 2'b01, 3'b010, 4'd6, 1'b1);
    chk("misalign_latency", {31'd0, bus.out_valid}, 32'd1);
    chk("misalign_no_req", {31'd0, bus.mem_req_valid}, 32'd0);
    drain();
    slv_err = 1'b1;
    exp_req(32'h8000_0004, 1'b0, 32'h0, 4'b0000);
    exp_out(32'h0, 1'b1, 4'd4, 1'b0, 1'b0, 1'b1);
    send(32'h8000_0004, 32'h0, 32'h0, 2'b01, 3'b010, 4'd4, 1'b1);
    drain();
    slv_err = 1'b0;
    bus.out_ready = 1'b0;
    exp_out(32'hAAAA, 1'b0, 4'd1, 1'b1, 1'b0, 1'b0);
    exp_out(32'hBBBB, 1'b0, 4'd2, 1'b1, 1'b0, 1'b0);
    send(32'hAAAA, 32'hAAAA, 32'h0, 2'b11, 3'b010, 4'd1, 1'b1);
    bus.alu_result_i = 32'hBBBB; bus.wdata_gpr_i = 32'hBBBB; bus.Gpr_Write_Addr_i = 4'd2;
    bus.sram_read_write_i = 2'b00; bus.in_valid = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("stall_in_ready", {31'd0, bus.in_ready}, 32'd0);
      chk("stall_wb_hold", bus.wb_data_o, 32'hAAAA);
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("release_in_ready", {31'd0, bus.in_ready}, 32'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk("release_next", bus.wb_data_o, 32'hBBBB);
    drain();
    slv_rdelay = 3;
    exp_req(32'h8000_0008, 1'b0, 32'h0, 4'b0000);
    send(32'h8000_0008, 32'h0, 32'h0, 2'b01, 3'b010, 4'd8, 1'b1);
    n = 0;
    @(negedge clk);
    while (bus.mem_req_valid && n < 50) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    bus.flush_i = 1'b1;
    @(negedge clk);
    chk("flush_blocks", {31'd0, bus.in_ready}, 32'd0);
    @(posedge clk); #1;
    bus.flush_i = 1'b0;
    n = 0;
    @(negedge clk);
    while (!bus.mem_resp_valid && n < 50) begin @(negedge clk); n++; end
    chk("flush_resp_seen", {31'd0, bus.mem_resp_valid}, 32'd1);
    @(posedge clk); #1;
    chk("flush_dropped", {31'd0, bus.out_valid}, 32'd0);
    chk("flush_idle", {31'd0, bus.in_ready}, 32'd1);
    @(posedge clk); #1;
    chk("flush_still_empty", {31'd0, bus.out_valid}, 32'd0);
    slv_rdelay = 0;
    slv_delay = 20;
    exp_req(32'h8000_000C, 1'b0, 32'h0, 4'b0000);
    send(32'h8000_000C, 32'h0, 32'h0, 2'b01, 3'b010, 4'd10, 1'b1);
    @(negedge clk);
    chk("req_pending", {31'd0, bus.mem_req_valid}, 32'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("reset_kills_req", {31'd0, bus.mem_req_valid}, 32'd0);
    chk("reset_out_valid", {31'd0, bus.out_valid}, 32'd0);
    reset = 1'b0;
    rq.delete();
    slv_delay = 0;
    @(negedge clk);
    chk("post_reset_ready", {31'd0, bus.in_ready}, 32'd1);
    @(posedge clk); #1;
    exp_out(32'h55, 1'b0, 4'd11, 1'b1, 1'b0, 1'b0);
    send(32'h55, 32'h55, 32'h0, 2'b00, 3'b010, 4'd11, 1'b1);
    drain();
    chk("out_queue_empty", oq.size(), 32'd0);
    chk("req_queue_empty", rq.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/ysyx_24100006_mem_access.md
Name: ysyx_24100006_mem_access

Overview:
Memory-access stage that consumes the EXE→MEM pipeline register's valid/ready output and turns each entry into at most one data-bus transaction.
- Loads and stores issue one request/response exchange. Loads are aligned and sign/zero-extended.
- Non-memory entries pass straight through.
- Results go to the MEM→WB register through a registered valid/ready output.
- Sits between the EXE_MEM register and MEM_WB, acting as initiator on the data bus.

Parameters:
ADDR_W, 32, data bus address width
DATA_W, 32, data width (fixed 32; byte-lane logic assumes 4 lanes)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
in_valid  in  1  entry valid from EXE_MEM
in_ready  out  1  stage can accept entry
alu_result_i  in  32  memory address, or result for non-memory ops
wdata_gpr_i  in  32  writeback data for non-memory ops
store_data_i  in  32  store source (rs2)
sram_read_write_i  in  2  00 none, 01 load, 10 store, 11 treated as none
Mem_Mask_i  in  3  [1:0] 00 byte / 01 half / 10,11 word; [2]=1 zero-extend
Gpr_Write_Addr_i  in  4  destination register
Gpr_Write_i  in  1  register write enable
flush_i  in  1  pipeline flush
mem_req_valid  out  1  bus request valid
mem_req_ready  in  1  bus accepts request
mem_req_we  out  1  1 = store
mem_req_addr  out  32  byte address (unaligned value passed through)
mem_req_wdata  out  32  lane-replicated store data
mem_req_wstrb  out  4  byte strobes (0000 for loads)
mem_resp_valid  in  1  response valid (load data or store ack)
mem_resp_rdata  in  32  load data, word-aligned
mem_resp_err  in  1  bus error with response
out_valid  out  1  result valid to MEM_WB
out_ready  in  1  MEM_WB accepts
wb_data_o  out  32  writeback data
Gpr_Write_Addr_o  out  4  destination register
Gpr_Write_o  out  1  write enable; forced 0 on fault or misalign
misalign_o  out  1  misaligned access detected
access_fault_o  out  1  bus error returned

Behaviour:
Reset:
- Synchronous and active-high. Takes effect at the next clk edge, including mid-transaction.
- State←IDLE. out_valid, mem_req_valid, Gpr_Write_o, misalign_o and access_fault_o ←0.
- wb_data_o ←0 and Gpr_Write_Addr_o ←0.
- The bus slave is reset on the same reset.

States:
- IDLE, REQ and RESP.
- in_ready = (state==IDLE) && !flush_i && (!out_valid || out_ready).

IDLE:
- An entry is accepted when in_valid && in_ready; all fields are latched.
- Misalign check: half with addr[0]=1, or word with addr[1:0]≠00.
- A non-memory op (00/11) or a misaligned load/store goes straight to the output register on the next edge, giving 1-cycle latency. State stays IDLE and no bus request is made.
  - Non-memory op: wb_data_o=wdata_gpr_i.
  - Misaligned access: misalign_o=1 and Gpr_Write_o=0.
- An aligned load/store moves the state to REQ.

REQ:
- mem_req_valid=1, with all mem_req_* fields held stable until mem_req_ready.
- On mem_req_ready: mem_req_valid drops on the next edge and the state moves to RESP.

RESP:
- Wait for mem_resp_valid; a response is never expected in the same cycle as the request handshake.
- On mem_resp_valid: the output register loads and out_valid=1. State returns to IDLE.
- If mem_resp_err: access_fault_o=1 and Gpr_Write_o=0.

Store lanes (a = addr[1:0]):
- Byte: wdata={4{d[7:0]}}, wstrb=0001<<a.
- Half: wdata={2{d[15:0]}}, wstrb=0011<<a.
- Word: wstrb=1111.

Load extract:
- Take rdata>>(8*a).
- Byte/half are sign-extended when Mem_Mask[2]=0, zero-extended when 1.

Output register:
- Holds while out_valid && !out_ready.
- Clears on out_ready when no new result arrives.
- A new result may load in the same cycle the old one is taken.

flush_i:
- Clears out_valid at the next edge and blocks acceptance that cycle.
- An in-flight REQ/RESP transaction is never abandoned. It completes on the bus, its result is discarded (out_valid stays 0), and the state returns to IDLE.

Test Plan:
- Non-memory op: alu/wdata_gpr=0x1234, Gpr_Write=1, addr x5 → out_valid one cycle after accept, wb_data_o=0x1234, Gpr_Write_Addr_o=5, no mem_req_valid.
- Byte load, addr 0x80000003, rdata 0x80FF_0000, Mask=000 → wb_data_o=0xFFFFFF80; with Mask=100 → 0x00000080; mem_req_wstrb=0000.
- Half store, addr 0x80000002, store_data 0xAAAA_BEEF → mem_req_wdata=0xBEEFBEEF, wstrb=1100; mem_req_ready held low 3 cycles → request fields stable throughout.
- Word load at addr 0x80000001 → misalign_o=1, Gpr_Write_o=0, no bus request, out_valid after 1 cycle; load with mem_resp_err=1 → access_fault_o=1, Gpr_Write_o=0.
- out_ready=0 for 4 cycles with result held → in_ready=0, wb_data_o stable; next entry accepted in the cycle out_ready rises.
- flush_i in RESP → transaction completes, out_valid stays 0, state returns to IDLE; reset asserted in REQ → mem_req_valid=0 next edge, in_ready=1 the cycle after reset deasserts.
